// File: rtl/operand_sequencer_if.sv
// Bus bundle between operand_sequencer and its neighbours: A/B load, row/column issue,
// scalar result return and C hand-off. slave = sequencer side, master = environment side.
interface operand_sequencer_if #(
  parameter int unsigned number_of_elements = 4
);
  localparam int unsigned VecW = 32 * number_of_elements;
  localparam int unsigned MatW = 32 * number_of_elements * number_of_elements;

  logic [MatW-1:0] a;
  logic            a_i_stb;
  logic            a_i_ack;
  logic [MatW-1:0] b;
  logic            b_i_stb;
  logic            b_i_ack;
  logic [VecW-1:0] row;
  logic            row_o_stb;
  logic            row_o_ack;
  logic [VecW-1:0] column;
  logic            column_o_stb;
  logic            column_o_ack;
  logic [31:0]     result;
  logic            result_i_stb;
  logic            result_i_ack;
  logic [MatW-1:0] c;
  logic            c_o_stb;
  logic            c_o_ack;

  modport slave (
    input  a, a_i_stb, b, b_i_stb, row_o_ack, column_o_ack, result, result_i_stb, c_o_ack,
    output a_i_ack, b_i_ack, row, row_o_stb, column, column_o_stb, result_i_ack, c, c_o_stb
  );

  modport master (
    output a, a_i_stb, b, b_i_stb, row_o_ack, column_o_ack, result, result_i_stb, c_o_ack,
    input  a_i_ack, b_i_ack, row, row_o_stb, column, column_o_stb, result_i_ack, c, c_o_stb
  );
endinterface

// File: rtl/operand_sequencer.sv
// Walks every (i,j) of C = A x B, issuing row i / column j to an inner-product unit and
// collecting results. OPERAND_SEQUENCER_PERF_EN adds a saturating busy-cycle counter `cycles`.
module operand_sequencer #(
  parameter int unsigned number_of_elements = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  operand_sequencer_if.slave     bus
`ifdef OPERAND_SEQUENCER_PERF_EN
  ,
  output logic [31:0]            cycles
`endif
);
  localparam int unsigned N    = number_of_elements;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MatW = 32 * N * N;
  localparam logic [IdxW-1:0] Last = IdxW'(N - 1);

  typedef enum logic [2:0] {StIdle, StSend, StWaitRes, StNext, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] i_q, i_d, j_q, j_d;
  logic [MatW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic            row_stb_q, row_stb_d, col_stb_q, col_stb_d;
  logic            load_ack_q, load_ack_d;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    row_stb_d  = row_stb_q;
    col_stb_d  = col_stb_q;
    load_ack_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.a_i_stb && bus.b_i_stb) begin
          a_d        = bus.a;
          b_d        = bus.b;
          c_d        = '0;
          i_d        = '0;
          j_d        = '0;
          load_ack_d = 1'b1;
          row_stb_d  = 1'b1;
          col_stb_d  = 1'b1;
          state_d    = StSend;
        end
      end
      StSend: begin
        // Each vector retires on its own; move on once both have been taken.
        if (row_stb_q && bus.row_o_ack) row_stb_d = 1'b0;
        if (col_stb_q && bus.column_o_ack) col_stb_d = 1'b0;
        if (!row_stb_d && !col_stb_d) state_d = StWaitRes;
      end
      StWaitRes: begin
        if (bus.result_i_stb) begin
          c_d[32 * (int'(i_q) * N + int'(j_q)) +: 32] = bus.result;
          state_d = StNext;
        end
      end
      StNext: begin
        if (i_q == Last && j_q == Last) begin
          i_d     = '0;
          j_d     = '0;
          state_d = StDone;
        end else begin
          if (j_q == Last) begin
            j_d = '0;
            i_d = i_q + IdxW'(1);
          end else begin
            j_d = j_q + IdxW'(1);
          end
          row_stb_d = 1'b1;
          col_stb_d = 1'b1;
          state_d   = StSend;
        end
      end
      StDone: begin
        if (bus.c_o_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      i_q        <= '0;
      j_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      row_stb_q  <= 1'b0;
      col_stb_q  <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      row_stb_q  <= row_stb_d;
      col_stb_q  <= col_stb_d;
      load_ack_q <= load_ack_d;
    end
  end

  // Vectors are pure selects of stored operands, so they read zero while in reset.
  always_comb begin
    bus.row    = '0;
    bus.column = '0;
    for (int unsigned k = 0; k < N; k++) begin
      bus.row[32 * k +: 32]    = a_q[32 * (int'(i_q) * N + k) +: 32];
      bus.column[32 * k +: 32] = b_q[32 * (k * N + int'(j_q)) +: 32];
    end
  end

  assign bus.a_i_ack      = load_ack_q;
  assign bus.b_i_ack      = load_ack_q;
  assign bus.row_o_stb    = row_stb_q;
  assign bus.column_o_stb = col_stb_q;
  assign bus.result_i_ack = (state_q == StSend) || (state_q == StWaitRes);
  assign bus.c            = c_q;
  assign bus.c_o_stb      = (state_q == StDone);

`ifdef OPERAND_SEQUENCER_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (state_q == StIdle && state_d == StSend) begin
      cycles_d = '0;
    end else if ((state_q == StSend || state_q == StWaitRes || state_q == StNext) &&
                 cycles_q != 32'hFFFF_FFFF) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycles_q <= '0;
    else      cycles_q <= cycles_d;
  end

  assign cycles = cycles_q;
`endif
endmodule
